// File: rtl/dst_pass_sequencer_if.sv
// Bus bundle linking the DST pass sequencer to its row source, the shared
// 4-point engine and the downstream quantiser.
interface dst_pass_sequencer_if #(
    parameter int IN_W  = 12,
    parameter int MID_W = 16,
    parameter int ENG_W = 26,
    parameter int OUT_W = 16
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0][IN_W-1:0]  in_row;
    logic [3:0][MID_W-1:0] eng_in;
    logic [3:0][ENG_W-1:0] eng_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0][OUT_W-1:0] out_col;
    logic [1:0]            out_idx;
    logic                  out_last;
    logic                  block_done;

    // master: the environment (row source, engine, quantiser); slave: the sequencer
    modport master (
        output in_valid, in_row, eng_out, out_ready,
        input  in_ready, eng_in, out_valid, out_col, out_idx, out_last, block_done
    );
    modport slave (
        input  in_valid, in_row, eng_out, out_ready,
        output in_ready, eng_in, out_valid, out_col, out_idx, out_last, block_done
    );
endinterface

// File: rtl/dst_pass_sequencer.sv
// Time-shares one combinational 4-point DST engine across the row and column
// passes of a 4x4 forward DST, using an internal transpose buffer.
module dst_pass_sequencer #(
    parameter int IN_W    = 12,
    parameter int COEFF_W = 8,
    parameter int MID_W   = 16,
    parameter int ENG_W   = MID_W + COEFF_W + 2,
    parameter int OUT_W   = 16,
    parameter int SHIFT1  = 1,
    parameter int SHIFT2  = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    dst_pass_sequencer_if.slave seq_io
);
    typedef enum logic {S_ROW, S_COL} state_e;

    localparam logic signed [ENG_W:0] MID_MAX = {{(ENG_W-MID_W+2){1'b0}}, {(MID_W-1){1'b1}}};
    localparam logic signed [ENG_W:0] MID_MIN = ~MID_MAX;
    localparam logic signed [ENG_W:0] OUT_MAX = {{(ENG_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ENG_W:0] OUT_MIN = ~OUT_MAX;

    // Round-half-up arithmetic shift; one guard bit keeps the rounding add from wrapping.
    function automatic logic signed [ENG_W:0] round_shift(input logic signed [ENG_W-1:0] x,
                                                          input int s);
        logic signed [ENG_W:0] xe;
        logic signed [ENG_W:0] half;
        xe   = {x[ENG_W-1], x};
        half = ({{ENG_W{1'b0}}, 1'b1} << s) >> 1;
        return (xe + half) >>> s;
    endfunction

    function automatic logic [MID_W-1:0] sat_mid(input logic signed [ENG_W:0] t);
        if (t > MID_MAX) return MID_MAX[MID_W-1:0];
        if (t < MID_MIN) return MID_MIN[MID_W-1:0];
        return t[MID_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] sat_out(input logic signed [ENG_W:0] t);
        if (t > OUT_MAX) return OUT_MAX[OUT_W-1:0];
        if (t < OUT_MIN) return OUT_MIN[OUT_W-1:0];
        return t[OUT_W-1:0];
    endfunction

    state_e                     state_q, state_d;
    logic [1:0]                 r_q, r_d, c_q, c_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic [1:0]                 out_idx_q, out_idx_d;
    logic [3:0][OUT_W-1:0]      out_col_q, out_col_d;
    logic [3:0][3:0][MID_W-1:0] tbuf_q, tbuf_d;
    logic [3:0][MID_W-1:0]      eng_in_w, row_res;
    logic [3:0][OUT_W-1:0]      col_res;
    logic                       in_ready_w, row_acc, col_load;

    assign in_ready_w = rst_n_i && (state_q == S_ROW);
    assign row_acc    = seq_io.in_valid && in_ready_w;
    assign col_load   = (state_q == S_COL) && (!out_valid_q || seq_io.out_ready);

    // Engine operand mux and both rounding paths; only one is consumed per state.
    always_comb begin
        eng_in_w = '0;
        row_res  = '0;
        col_res  = '0;
        for (int n = 0; n < 4; n++) begin
            if (state_q == S_ROW)
                eng_in_w[n] = {{(MID_W-IN_W){seq_io.in_row[n][IN_W-1]}}, seq_io.in_row[n]};
            else
                eng_in_w[n] = tbuf_q[n][c_q];
            row_res[n] = sat_mid(round_shift(seq_io.eng_out[n], SHIFT1));
            col_res[n] = sat_out(round_shift(seq_io.eng_out[n], SHIFT2));
        end
    end

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        c_d         = c_q;
        tbuf_d      = tbuf_q;
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        case (state_q)
            S_ROW: if (row_acc) begin
                tbuf_d[r_q] = row_res;
                r_d         = r_q + 2'd1;
                if (r_q == 2'd3) begin
                    state_d = S_COL;
                    c_d     = 2'd0;
                end
            end
            S_COL: if (col_load) begin
                c_d = c_q + 2'd1;
                // Column 3 sits in the output register, so the buffer is free for the next block.
                if (c_q == 2'd3) begin
                    state_d = S_ROW;
                    r_d     = 2'd0;
                end
            end
            default: state_d = S_ROW;
        endcase
        if (col_load) begin
            out_valid_d = 1'b1;
            out_col_d   = col_res;
            out_idx_d   = c_q;
            out_last_d  = (c_q == 2'd3);
        end else if (seq_io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= S_ROW;
            r_q         <= 2'd0;
            c_q         <= 2'd0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
            out_idx_q   <= 2'd0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    // Buffer content is don't-care after reset; every block rewrites all four rows.
    always_ff @(posedge clk_i) begin
        tbuf_q <= tbuf_d;
    end

    assign seq_io.in_ready   = in_ready_w;
    assign seq_io.eng_in     = eng_in_w;
    assign seq_io.out_valid  = out_valid_q;
    assign seq_io.out_col    = out_col_q;
    assign seq_io.out_idx    = out_idx_q;
    assign seq_io.out_last   = out_last_q;
    assign seq_io.block_done = out_valid_q && seq_io.out_ready && out_last_q;
endmodule

// File: doc/dst_pass_sequencer.md
# dst_pass_sequencer

- Sequences one shared, combinational 4-point DST engine through both passes of the 4×4 forward DST: a row pass, then a column pass.
- Accepts a block row-by-row on a valid/ready input, runs each row through the engine, and stores the rounded results in an internal 4×4 transpose buffer.
- Then feeds the buffer's columns through the same engine and emits one rounded output column per handshake.
- Sits between the residual source and the quantiser, replacing separate row and column transform instances.

## Interface
- IN_W, 12, signed input sample width
- COEFF_W, 8, engine coefficient width (engine-internal; sets ENG_W)
- MID_W, 16, transpose-buffer word width and engine input width
- ENG_W, MID_W+COEFF_W+2, engine output width
- OUT_W, 16, output coefficient width
- SHIFT1, 1, row-pass rounding shift
- SHIFT2, 8, column-pass rounding shift
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input row valid
- in_ready  out  1  sequencer accepts a row
- in_row[0:3]  in  4×IN_W signed  one block row, element n = column n
- eng_in[0:3]  out  4×MID_W signed  to shared engine
- eng_out[0:3]  in  4×ENG_W signed  engine result, same cycle, out[k]=Σ M[k][n]·in[n]
- out_valid  out  1  output column valid (registered)
- out_ready  in  1  downstream accepts
- out_col[0:3]  out  4×OUT_W signed  element k = coefficient row k of column out_idx
- out_idx  out  2  column index 0..3
- out_last  out  1  high with column 3
- block_done  out  1  one-cycle pulse when the column-3 handshake completes

## Operation
- FSM, two states:
  - S_ROW: row counter r; in_ready=1.
  - S_COL: column counter c; in_ready=0.
- Reset state is S_ROW with r=c=0.
- eng_in mux:
  - In S_ROW: in_row sign-extended to MID_W.
  - In S_COL: buffer column c, i.e. buf[0][c]..buf[3][c].
- Rounding function rs(x,S):
  - (x + (1<<(S-1))) >>> S, arithmetic; for S=0, x unchanged.
  - The result then saturates to the destination signed range.
- S_ROW: on in_valid&in_ready, buf[r][k] ← sat_MID(rs(eng_out[k],SHIFT1)) and r increments. On accepting r=3, the next state is S_COL with c=0.
- S_COL: when !out_valid || out_ready, the output register loads:
  - out_col[k] ← sat_OUT(rs(eng_out[k],SHIFT2))
  - out_idx ← c, out_last ← (c==3), out_valid ← 1, c increments
  - On loading c=3, the next state is S_ROW with r=0.
- S_COL with out_valid && !out_ready: hold all output fields stable; c does not advance.
- Output register clear: out_valid←0 on out_ready when nothing new is loaded that cycle.
- block_done=1 in the cycle out_valid&out_ready&out_last.
- Column 3 is captured before returning to S_ROW, so the next block's row 0 may overwrite the buffer while column 3 is still stalled at the output.
- Reset mid-block (rst_n low on any edge):
  - State ← S_ROW, r=c=0, out_valid=0, out_col=0, out_idx=0, out_last=0.
  - The partial block is discarded; buffer contents are don't-care.

## Timing
- Reset values: out_valid=0, out_col=0, out_idx=0, out_last=0, block_done=0. in_ready=0 while rst_n=0, and 1 the cycle after release.
- eng_in is combinational from state and counters/in_row; the engine result is consumed in the same cycle.
- Latency: the last row handshake is at cycle t → S_COL at t+1 → column 0 load at t+1 → out_valid at t+2.
- Peak throughput with no backpressure: one block per 8 cycles (4 row accepts + 4 column loads); in_ready low for 4 cycles per block.
- Simultaneous handshakes:
  - A cycle with out_valid&out_ready and S_COL loads the next column: no bubble.
  - In S_ROW, a pending output and an input accept proceed independently.

## Test plan
- All-zero block, out_ready=1 → four columns of all zeros at out_idx 0..3; out_last with idx 3; one block_done pulse; 8 cycles from first accept to last load.
- Every row {1,0,0,0} (M = HEVC DST: [29 55 74 84; 74 74 0 -74; 84 -29 -74 55; 55 -84 74 -29]) → buffer rows {15,37,42,28}; out_col for idx 0 = {14,4,2,1}.
- All samples 2047 → buffer saturates to 32767 in columns 0–2; out_col idx 0 = {30975,9472,4608,2048}; no wrap.
- out_ready low for 5 cycles on column 1 → out_col/out_idx held stable; c does not advance; columns delivered in order 0..3 with none lost or duplicated.
- Back-to-back blocks, in_valid held high, column 3 stalled 3 cycles → next block rows accepted during the stall; column 3 value unchanged; second block's outputs correct.
- rst_n low for 1 cycle after row 2 of a block → outputs at reset values; a fresh full block then produces correct results with no residue from the partial block.
